// File: rtl/block_mem_responder.sv
// Memory-side responder for block reads and writes: one block at a time, moved
// word-serially to or from a word-wide backing RAM after a fixed access latency.
// Ports:
//   i_clk, i_arst            clock, synchronous active-high reset
//   i_axi_read_start         block-read request, level held until done
//   i_axi_write_start        block-write request, level held until done
//   i_axi_addr               byte address of the block
//   i_data_block             write block from the core
//   o_data_block             last completed read block
//   o_axi_done               one-cycle completion pulse
//   o_busy                   high from acceptance through the done cycle
module block_mem_responder #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int WORD_WIDTH  = 64,
  parameter int MEM_WORDS   = 4096,
  parameter int LATENCY     = 4,
  parameter     INIT_FILE   = ""
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_axi_read_start,
  input  logic                   i_axi_write_start,
  input  logic [ADDR_WIDTH-1:0]  i_axi_addr,
  input  logic [BLOCK_WIDTH-1:0] i_data_block,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic                   o_axi_done,
  output logic                   o_busy
);

  localparam int BEATS = BLOCK_WIDTH / WORD_WIDTH;
  localparam int OFS   = $clog2(BLOCK_WIDTH / 8);
  localparam int IW    = $clog2(MEM_WORDS);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(LATENCY + 2);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [CW-1:0] LAT_LAST  =
    CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  if (BLOCK_WIDTH % WORD_WIDTH != 0) begin : g_chk
    $error("BLOCK_WIDTH must be a multiple of WORD_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic                   op_wr_q;
  logic                   arm_wr_q;
  logic                   arm_rd_q;
  logic                   done_q;
  logic                   busy_q;
  logic [IW-1:0]          base_q;
  logic [BW-1:0]          beat_q;
  logic [CW-1:0]          cnt_q;
  logic [BLOCK_WIDTH-1:0] wblk_q;
  logic [BLOCK_WIDTH-1:0] rblk_q;
  logic [WORD_WIDTH-1:0]  mem_q [MEM_WORDS];

  logic                   wr_go;
  logic                   rd_go;
  logic [ADDR_WIDTH-1:0]  blk_idx;
  logic [IW-1:0]          base_d;
  logic [IW-1:0]          widx;
  logic                   mem_we;

  // Writes win a tie; each start must be armed (seen low since its
  // last completion) so a held request is never served twice.
  assign wr_go   = i_axi_write_start & arm_wr_q;
  assign rd_go   = i_axi_read_start & arm_rd_q & ~wr_go;
  assign blk_idx = i_axi_addr >> OFS;
  // Word index wraps modulo the RAM depth by truncation.
  assign base_d  = IW'(blk_idx * ADDR_WIDTH'(BEATS));
  assign widx    = base_q + IW'(beat_q);
  // Reset blocks the beat it coincides with; earlier beats stay committed.
  assign mem_we  = ~i_arst & (state_q == S_XFER) & op_wr_q;

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[widx] <= wblk_q[beat_q*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q  <= S_IDLE;
      op_wr_q  <= 1'b0;
      arm_wr_q <= 1'b1;
      arm_rd_q <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      base_q   <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      wblk_q   <= '0;
      rblk_q   <= '0;
    end else begin
      if (!i_axi_write_start) arm_wr_q <= 1'b1;
      if (!i_axi_read_start)  arm_rd_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (wr_go || rd_go) begin
            op_wr_q <= wr_go;
            base_q  <= base_d;
            beat_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (wr_go) wblk_q <= i_data_block;
            state_q <= (LATENCY == 0) ? S_XFER : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == LAT_LAST) begin
            state_q <= S_XFER;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_XFER: begin
          if (!op_wr_q) begin
            rblk_q[beat_q*WORD_WIDTH +: WORD_WIDTH] <= mem_q[widx];
          end
          if (beat_q == BEAT_LAST) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          // Overrides the arming above: this completion needs a fresh low.
          if (op_wr_q) arm_wr_q <= 1'b0;
          else         arm_rd_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data_block = rblk_q;
  assign o_axi_done   = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder: one instance at LATENCY 4 and
// one at LATENCY 0, table of block ops plus corner-case sequences.
module tb_block_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         arst [2];
  logic         rd   [2];
  logic         wr   [2];
  logic [63:0]  addr [2];
  logic [511:0] wdat [2];
  logic [511:0] rdat [2];
  logic         done [2];
  logic         busy [2];

  block_mem_responder #(.LATENCY(4)) dut (
    .i_clk(clk), .i_arst(arst[0]),
    .i_axi_read_start(rd[0]), .i_axi_write_start(wr[0]),
    .i_axi_addr(addr[0]), .i_data_block(wdat[0]),
    .o_data_block(rdat[0]), .o_axi_done(done[0]), .o_busy(busy[0])
  );

  block_mem_responder #(.LATENCY(0)) dz (
    .i_clk(clk), .i_arst(arst[1]),
    .i_axi_read_start(rd[1]), .i_axi_write_start(wr[1]),
    .i_axi_addr(addr[1]), .i_data_block(wdat[1]),
    .o_data_block(rdat[1]), .o_axi_done(done[1]), .o_busy(busy[1])
  );

  typedef struct {
    int           z;
    bit           w;
    logic [63:0]  a;
    logic [511:0] d;
    int           n;
    logic [511:0] e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [511:0] blk_a, blk_b, blk_c, blk_d, blk_m;
  vec_t tbl [7];

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // n counts edges from raising start; accept is edge 1, so done is first
  // seen after edge LATENCY+BEATS+1.
  task automatic do_op(int z, bit w, logic [63:0] a, logic [511:0] d,
                       int exp_n, logic [511:0] exp_d, string nm);
    int n;
    bit got;
    @(negedge clk);
    addr[z] = a;
    wdat[z] = d;
    if (w) wr[z] = 1'b1;
    else   rd[z] = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk({nm, ".busy"}, busy[z], 1);
      if (done[z]) got = 1;
    end
    chk({nm, ".lat"}, n, exp_n);
    @(posedge clk); #1;
    chk({nm, ".done1"}, done[z], 0);
    chk({nm, ".idle"}, busy[z], 0);
    if (!w) chk({nm, ".data"}, rdat[z], exp_d);
    wr[z] = 1'b0;
    rd[z] = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int pulses;
    for (int k = 0; k < 8; k++) begin
      blk_a[k*64 +: 64] = 64'(k + 1) * 64'h11;
      blk_b[k*64 +: 64] = 64'hB0B0_0000_0000_0000 | 64'(k);
      blk_c[k*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(3 * k);
      blk_d[k*64 +: 64] = 64'hD00D_0000_0000_0000 | 64'(k);
      blk_m[k*64 +: 64] = (k < 3) ? blk_d[k*64 +: 64] : blk_b[k*64 +: 64];
    end
    tbl[0] = '{0, 1, 64'h40,   blk_a, 13, '0};
    tbl[1] = '{0, 0, 64'h47,   '0,    13, blk_a};
    tbl[2] = '{1, 1, 64'h8000, blk_b, 9,  '0};
    tbl[3] = '{1, 0, 64'h0,    '0,    9,  blk_b};
    tbl[4] = '{0, 0, 64'h8040, '0,    13, blk_a};
    tbl[5] = '{1, 1, 64'h1000, blk_c, 9,  '0};
    tbl[6] = '{1, 0, 64'h103F, '0,    9,  blk_c};

    for (int z = 0; z < 2; z++) begin
      arst[z] = 1'b1; rd[z] = 1'b0; wr[z] = 1'b0;
      addr[z] = '0; wdat[z] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int z = 0; z < 2; z++) begin
      chk("rst.data", rdat[z], 0);
      chk("rst.done", done[z], 0);
      chk("rst.busy", busy[z], 0);
      arst[z] = 1'b0;
    end
    @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].z, tbl[i].w, tbl[i].a, tbl[i].d,
            tbl[i].n, tbl[i].e, $sformatf("v%0d", i));
    end

    // Simultaneous starts: write first, then read without a new edge.
    @(negedge clk);
    addr[0] = 64'h80; wdat[0] = blk_c; wr[0] = 1'b1; rd[0] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done[0]) begin
        pulses++;
        if (pulses == 1) chk("t3.wr_first", rdat[0], blk_a);
      end
    end
    chk("t3.pulses", pulses, 2);
    chk("t3.rdata", rdat[0], blk_c);
    wr[0] = 1'b0; rd[0] = 1'b0;
    @(posedge clk);

    // Held read start served once; drop and re-raise serves again.
    @(negedge clk);
    addr[0] = 64'h40; rd[0] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done[0]) pulses++;
    end
    chk("t4.held", pulses, 1);
    rd[0] = 1'b0;
    @(posedge clk); #1;
    rd[0] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done[0]) pulses++;
    end
    chk("t4.rearm", pulses, 1);
    chk("t4.data", rdat[0], blk_a);
    rd[0] = 1'b0;
    @(posedge clk);

    // Reset at the edge of write beat 3 (LATENCY 0: beat k at edge k+2).
    @(negedge clk);
    addr[1] = 64'h0; wdat[1] = blk_d; wr[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    arst[1] = 1'b1;
    @(posedge clk); #1;
    chk("t6.busy", busy[1], 0);
    chk("t6.done", done[1], 0);
    chk("t6.data", rdat[1], 0);
    arst[1] = 1'b0; wr[1] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done[1]) pulses++;
    end
    chk("t6.nodone", pulses, 0);
    do_op(1, 0, 64'h0, '0, 9, blk_m, "t6.rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
